reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
//-----------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   Brings four reset domains out of reset one at a time. It waits for the
//   2-of-3 voted power-on reset and for the software reset request to drop.
//   It then holds every domain in reset for HOLD_CYCLES cycles. After that it
//   releases domain 0, 1, 2 and 3 in turn, and each domain must acknowledge
//   ready before the next one is released. A disagreement between the
//   power-on-reset replicas is recorded as a sticky flag and a saturating
//   count. The disagreement never affects sequencing.
//
// Optional feature (compile-time macro RESET_SEQ_TIMEOUT_EN):
//   When defined, each released domain has TIMEOUT_CYCLES cycles to
//   acknowledge. If it does not, the sequencer parks in FAULT, reports the
//   domain in faultDomain and re-asserts every domain reset. When undefined,
//   the sequencer waits indefinitely for the acknowledge and FAULT cannot be
//   reached.
//
// Parameters:
//   HOLD_CYCLES     cycles spent in HOLD before the first release (1..65535)
//   TIMEOUT_CYCLES  cycles allowed per domain for its acknowledge (1..65535)
//
// Ports:
//   clk          in   1  system clock
//   rst          in   1  asynchronous active-high reset
//   porStatus    in   3  power-on-reset replicas, 1 = in power-on reset
//   swRst        in   1  synchronous software reset request, level sensitive
//   ack          in   4  per-domain ready acknowledge
//   rstOut       out  4  per-domain reset, active high, bit 0 released first
//   done         out  1  sequencer in DONE
//   fault        out  1  sequencer in FAULT
//   faultDomain  out  2  domain that last timed out
//   porErr       out  1  sticky replica-disagreement flag
//   porErrCnt    out  8  saturating count of replica-disagreement cycles
//   state        out  3  ASSERT=0 HOLD=1 RELEASE=2 DONE=3 FAULT=4
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] porStatus,
    input  logic       swRst,
    input  logic [3:0] ack,
    output logic [3:0] rstOut,
    output logic       done,
    output logic       fault,
    output logic [1:0] faultDomain,
    output logic       porErr,
    output logic [7:0] porErrCnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_ASSERT  = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_DONE    = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    // The HOLD and RELEASE stages share one cycle counter. It is sized for
    // the larger terminal count so that the width is the same in either build.
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    // 2-of-3 majority of the power-on-reset replicas.
    function automatic logic vote_2of3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // The replicas disagree whenever they are not all equal.
    function automatic logic replicas_differ(input logic [2:0] v);
        return (v != 3'b000) && (v != 3'b111);
    endfunction

    // Domains 0..idx are out of reset; higher domains are still held.
    function automatic logic [3:0] release_mask(input logic [1:0] idx);
        return 4'b1111 << ({1'b0, idx} + 3'd1);
    endfunction

    state_t           r_state;
    logic [3:0]       r_rstOut;
    logic             r_done;
    logic             r_fault;
    logic [1:0]       r_faultDomain;
    logic             r_porErr;
    logic [7:0]       r_porErrCnt;
    logic [1:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;

    logic w_porVote;
    logic w_mismatch;
    logic w_restart;

    assign w_porVote  = vote_2of3(porStatus);
    assign w_mismatch = replicas_differ(porStatus);
    assign w_restart  = w_porVote | swRst;

    // Sequencer FSM: next state, domain resets and status flags, all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_ASSERT;
            r_rstOut      <= 4'b1111;
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
            r_faultDomain <= 2'd0;
            r_idx         <= 2'd0;
            r_cnt         <= '0;
        end else if (w_restart) begin
            // A voted power-on reset or a software reset wins from any state.
            r_state  <= ST_ASSERT;
            r_rstOut <= 4'b1111;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
            r_idx    <= 2'd0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    r_state  <= ST_HOLD;
                    r_rstOut <= 4'b1111;
                    r_done   <= 1'b0;
                    r_fault  <= 1'b0;
                    r_idx    <= 2'd0;
                    r_cnt    <= '0;
                end
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        // Domain 0 is released on the same edge that enters RELEASE.
                        r_state  <= ST_RELEASE;
                        r_rstOut <= release_mask(2'd0);
                        r_idx    <= 2'd0;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // ack[r_idx] is sampled only once rstOut[r_idx] is already low.
                    if (ack[r_idx]) begin
                        r_cnt <= '0;
                        if (r_idx == 2'd3) begin
                            r_state  <= ST_DONE;
                            r_rstOut <= 4'b0000;
                            r_done   <= 1'b1;
                        end else begin
                            r_idx    <= r_idx + 2'd1;
                            r_rstOut <= release_mask(r_idx + 2'd1);
                        end
                    end else begin
`ifdef RESET_SEQ_TIMEOUT_EN
                        if (r_cnt == TIMEOUT_LAST) begin
                            r_state       <= ST_FAULT;
                            r_rstOut      <= 4'b1111;
                            r_fault       <= 1'b1;
                            r_faultDomain <= r_idx;
                            r_idx         <= 2'd0;
                            r_cnt         <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
`else
                        r_cnt <= r_cnt;
`endif
                    end
                end
                ST_DONE: begin
                    r_rstOut <= 4'b0000;
                    r_done   <= 1'b1;
                end
                ST_FAULT: begin
                    r_rstOut <= 4'b1111;
                    r_fault  <= 1'b1;
                end
                default: begin
                    r_state  <= ST_ASSERT;
                    r_rstOut <= 4'b1111;
                    r_done   <= 1'b0;
                    r_fault  <= 1'b0;
                    r_idx    <= 2'd0;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

    // Replica disagreement monitor: sticky flag plus saturating cycle count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_porErr    <= 1'b0;
            r_porErrCnt <= 8'd0;
        end else if (w_mismatch) begin
            r_porErr <= 1'b1;
            if (r_porErrCnt != 8'hFF) begin
                r_porErrCnt <= r_porErrCnt + 8'd1;
            end else begin
                r_porErrCnt <= r_porErrCnt;
            end
        end else begin
            r_porErr    <= r_porErr;
            r_porErrCnt <= r_porErrCnt;
        end
    end

    assign rstOut      = r_rstOut;
    assign done        = r_done;
    assign fault       = r_fault;
    assign faultDomain = r_faultDomain;
    assign porErr      = r_porErr;
    assign porErrCnt   = r_porErrCnt;
    assign state       = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps

module tb_reset_sequencer;

    localparam int HOLD = 16;
    localparam int TMO  = 8;
`ifdef RESET_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int ST_A = 0, ST_H = 1, ST_R = 2, ST_D = 3, ST_F = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] porStatus = 3'b000;
    logic       swRst = 1'b0;
    logic [3:0] ack = 4'b0000;
    logic [3:0] rstOut;
    logic       done;
    logic       fault;
    logic [1:0] faultDomain;
    logic       porErr;
    logic [7:0] porErrCnt;
    logic [2:0] state;

    int vecs  = 0;
    int fails = 0;

    reset_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .porStatus(porStatus), .swRst(swRst), .ack(ack),
        .rstOut(rstOut), .done(done), .fault(fault), .faultDomain(faultDomain),
        .porErr(porErr), .porErrCnt(porErrCnt), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: phase, number of released domains, cycles in phase.
    typedef struct {
        int st;
        int released;
        int cnt;
        int fdom;
        bit perr;
        int pcnt;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.st = ST_A; r.released = 0; r.cnt = 0; r.fdom = 0; r.perr = 1'b0; r.pcnt = 0;
        return r;
    endfunction

    function automatic model_t model_next(model_t c, logic [2:0] por, logic sw, logic [3:0] a);
        model_t n;
        int idx;
        int ones;
        n = c;
        ones = $countones(por);
        if (ones != 0 && ones != 3) begin
            n.perr = 1'b1;
            if (c.pcnt < 255) n.pcnt = c.pcnt + 1;
        end
        if (ones >= 2 || sw) begin
            n.st = ST_A; n.released = 0; n.cnt = 0;
            return n;
        end
        case (c.st)
            ST_A: begin n.st = ST_H; n.cnt = 0; end
            ST_H: begin
                n.cnt = c.cnt + 1;
                if (n.cnt == HOLD) begin n.st = ST_R; n.released = 1; n.cnt = 0; end
            end
            ST_R: begin
                idx = c.released - 1;
                if (a[idx[1:0]]) begin
                    n.cnt = 0;
                    if (c.released == 4) n.st = ST_D;
                    else n.released = c.released + 1;
                end else if (TO_EN) begin
                    n.cnt = c.cnt + 1;
                    if (n.cnt == TMO) begin n.st = ST_F; n.fdom = idx; n.released = 0; n.cnt = 0; end
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic [19:0] exp_vec(model_t c);
        logic [3:0] ones4;
        logic [3:0] ro;
        ones4 = 4'b1111;
        ro = (c.st == ST_R || c.st == ST_D) ? (ones4 << c.released) : 4'b1111;
        return {3'(c.st), ro, (c.st == ST_D), (c.st == ST_F), 2'(c.fdom), c.perr, 8'(c.pcnt)};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {state, rstOut, done, fault, faultDomain, porErr, porErrCnt};
    endfunction

    // Model advances on the same edges as the design.
    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_next(m, porStatus, swRst, ack);
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; porStatus = 3'b000; swRst = 1'b0; ack = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vecs++;
        if (dut_vec() !== {3'd0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0}) begin
            fails++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), 20'h1E000);
        end
        rst = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            vecs++;
            if (dut_vec() !== exp_vec(m)) begin
                fails++; $display("FAIL reset_exit cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec(m));
            end
        end
    endtask

    task automatic test_normal();
        int low[4];
        int hold_at, fall_at;
        logic [3:0] seen[$];
        hold_at = -1; fall_at = -1;
        for (int i = 0; i < 4; i++) low[i] = 0;
        apply_reset();
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            vecs++;
            if (dut_vec() !== exp_vec(m)) begin
                fails++; $display("FAIL normal cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec(m));
            end
            if (state === 3'd1 && hold_at < 0) hold_at = cyc;
            if (rstOut[0] === 1'b0 && fall_at < 0) fall_at = cyc;
            if (seen.size() == 0 || seen[seen.size()-1] !== rstOut) seen.push_back(rstOut);
            for (int i = 0; i < 4; i++) begin
                low[i] = (rstOut[i] === 1'b0) ? low[i] + 1 : 0;
                ack[i] = (low[i] >= 2);
            end
        end
        vecs++;
        if (hold_at < 0 || fall_at - hold_at != HOLD) begin
            fails++; $display("FAIL normal_hold_len got=%0d exp=%0d", fall_at - hold_at, HOLD);
        end
        vecs++;
        if (seen.size() != 5 || {seen[0], seen[1], seen[2], seen[3], seen[4]} !== 20'hFEC80) begin
            fails++; $display("FAIL normal_steps got_count=%0d exp_count=5 exp=FEC80", seen.size());
        end
        vecs++;
        if (done !== 1'b1 || rstOut !== 4'b0000) begin
            fails++; $display("FAIL normal_done got=%b/%b exp=1/0000", done, rstOut);
        end
    endtask

    task automatic test_voting();
        int low[4];
        int nmis;
        bit armed, checked;
        nmis = 0; armed = 1'b0; checked = 1'b0;
        for (int i = 0; i < 4; i++) low[i] = 0;
        apply_reset();
        for (int cyc = 0; cyc < 70; cyc++) begin
            @(negedge clk);
            vecs++;
            if (dut_vec() !== exp_vec(m)) begin
                fails++; $display("FAIL voting cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec(m));
            end
            if (armed) begin
                vecs++;
                if (state !== 3'd0 || rstOut !== 4'b1111) begin
                    fails++; $display("FAIL voting_restart got=%0d/%b exp=0/1111", state, rstOut);
                end
                armed = 1'b0; checked = 1'b1;
            end
            porStatus = 3'b000;
            if (state === 3'd1 && nmis < 5) begin
                porStatus = 3'b001; nmis++;
            end else if (state === 3'd2 && rstOut === 4'b1100 && !checked && !armed) begin
                vecs++;
                if (porErr !== 1'b1 || porErrCnt !== 8'd5) begin
                    fails++; $display("FAIL voting_porerr got=%b/%0d exp=1/5", porErr, porErrCnt);
                end
                porStatus = 3'b011; armed = 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                low[i] = (rstOut[i] === 1'b0) ? low[i] + 1 : 0;
                ack[i] = (low[i] >= 2);
            end
        end
        if (!checked) begin
            vecs++; fails++; $display("FAIL voting_reach got=0 exp=1");
        end
    endtask

    task automatic test_timeout();
        int low[4];
        int s2_at, f_at, stall;
        s2_at = -1; f_at = -1; stall = 0;
        for (int i = 0; i < 4; i++) low[i] = 0;
        apply_reset();
        for (int cyc = 0; cyc < (TO_EN ? 60 : 10100); cyc++) begin
            @(negedge clk);
            vecs++;
            if (dut_vec() !== exp_vec(m)) begin
                fails++; $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec(m));
            end
            if (rstOut === 4'b1000 && s2_at < 0) s2_at = cyc;
            if (state === 3'd4 && f_at < 0) f_at = cyc;
            if (state === 3'd2 && rstOut === 4'b1000 && fault === 1'b0) stall++;
            if (!TO_EN && stall >= 10000) break;
            for (int i = 0; i < 4; i++) begin
                low[i] = (rstOut[i] === 1'b0) ? low[i] + 1 : 0;
                ack[i] = (low[i] >= 2) && (i != 2);
            end
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        vecs++;
        if (s2_at < 0 || f_at - s2_at != TMO) begin
            fails++; $display("FAIL timeout_len got=%0d exp=%0d", f_at - s2_at, TMO);
        end
        vecs++;
        if (fault !== 1'b1 || faultDomain !== 2'd2 || rstOut !== 4'b1111) begin
            fails++; $display("FAIL timeout_fault got=%b/%0d/%b exp=1/2/1111", fault, faultDomain, rstOut);
        end
        swRst = 1'b1;
        @(negedge clk);
        swRst = 1'b0;
        vecs++;
        if (state !== 3'd0 || fault !== 1'b0 || faultDomain !== 2'd2) begin
            fails++; $display("FAIL timeout_swrst got=%0d/%b/%0d exp=0/0/2", state, fault, faultDomain);
        end
`else
        vecs++;
        if (stall < 10000) begin
            fails++; $display("FAIL no_timeout_wait got=%0d exp=10000", stall);
        end
        ack = 4'b1111;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            vecs++;
            if (dut_vec() !== exp_vec(m)) begin
                fails++; $display("FAIL no_timeout_end cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec(m));
            end
        end
        vecs++;
        if (done !== 1'b1 || rstOut !== 4'b0000 || fault !== 1'b0) begin
            fails++; $display("FAIL no_timeout_done got=%b/%b/%b exp=1/0000/0", done, rstOut, fault);
        end
`endif
    endtask

    task automatic test_ack_all();
        logic [3:0] prev;
        prev = 4'b1111;
        apply_reset();
        ack = 4'b1111;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            vecs++;
            if (dut_vec() !== exp_vec(m) || $countones(prev ^ rstOut) > 1) begin
                fails++; $display("FAIL ack_all cyc=%0d got=%h exp=%h prev=%b", cyc, dut_vec(), exp_vec(m), prev);
            end
            prev = rstOut;
        end
        vecs++;
        if (done !== 1'b1) begin
            fails++; $display("FAIL ack_all_done got=%b exp=1", done);
        end
        swRst = 1'b1;
        @(negedge clk);
        swRst = 1'b0;
        vecs++;
        if (state !== 3'd0 || rstOut !== 4'b1111 || done !== 1'b0) begin
            fails++; $display("FAIL done_swrst got=%0d/%b/%b exp=0/1111/0", state, rstOut, done);
        end
    endtask

    task automatic test_mid_reset();
        bit reached;
        reached = 1'b0;
        apply_reset();
        ack = 4'b0001;
        for (int cyc = 0; cyc < 40 && !reached; cyc++) begin
            @(negedge clk);
            vecs++;
            if (dut_vec() !== exp_vec(m)) begin
                fails++; $display("FAIL mid_reset cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec(m));
            end
            if (state === 3'd2 && rstOut === 4'b1100) reached = 1'b1;
        end
        vecs++;
        if (!reached) begin
            fails++; $display("FAIL mid_reset_reach got=0 exp=1");
        end
        #2 rst = 1'b1;
        #1;
        vecs++;
        if (dut_vec() !== {3'd0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0}) begin
            fails++; $display("FAIL mid_reset_async got=%h exp=%h", dut_vec(), 20'h1E000);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            vecs++;
            if (dut_vec() !== exp_vec(m)) begin
                fails++; $display("FAIL mid_reset_after cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec(m));
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        ack = 4'b1111;
        porStatus = 3'b001;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            vecs++;
            if (dut_vec() !== exp_vec(m)) begin
                fails++; $display("FAIL saturation cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec(m));
            end
        end
        porStatus = 3'b000;
        vecs++;
        if (porErrCnt !== 8'd255 || porErr !== 1'b1) begin
            fails++; $display("FAIL saturation_cnt got=%0d/%b exp=255/1", porErrCnt, porErr);
        end
        swRst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        swRst = 1'b0;
        vecs++;
        if (porErrCnt !== 8'd255 || porErr !== 1'b1 || state !== 3'd0) begin
            fails++; $display("FAIL saturation_swrst got=%0d/%b/%0d exp=255/1/0", porErrCnt, porErr, state);
        end
        apply_reset();
        vecs++;
        if (porErrCnt !== 8'd0 || porErr !== 1'b0) begin
            fails++; $display("FAIL saturation_rst got=%0d/%b exp=0/0", porErrCnt, porErr);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            vecs++;
            if (dut_vec() !== exp_vec(m)) begin
                fails++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec(m));
            end
            porStatus = ($urandom_range(0, 99) < 6) ? 3'($urandom_range(0, 7)) : 3'b000;
            swRst     = ($urandom_range(0, 99) < 1);
            ack       = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_voting();
        test_timeout();
        test_ack_all();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
